fe_branch_predictor: RTL
========================

Name: fe_branch_predictor

Overview:
- Gshare direction predictor plus direct-mapped BTB for the fetch stage.
- Each cycle it looks up the current fetch PC and produces the predicted next PC plus prediction metadata, which travels FE -> DE -> AGEX.
- Branches resolved in AGEX write back BHR, pattern-table and BTB updates through the update port.
- After reset, an internal init state machine sweeps the pattern table before fetch may proceed.

Parameters:
- DBITS, 32, data/PC width
- BHRBITS, 8, global history length; equals the PT index width
- PTENTRIES, 256, 2-bit saturating counters
- BTBENTRIES, 16, direct-mapped BTB entries; index = PC[5:2]
- TAGBITS, 26, BTB tag = PC[31:6]

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_pc  in  32  PC being fetched this cycle
- fetch_valid  in  1  a lookup is requested
- pred_next_pc  out  32  predicted next fetch PC
- pred_btb_hit  out  1  BTB tag match with valid bit set
- pred_taken  out  1  final taken prediction
- pred_target  out  32  BTB target (0 on miss)
- pred_pt_idx  out  8  gshare index used; carried down the pipe
- pred_btb_idx  out  4  BTB index used; carried down the pipe
- init_busy  out  1  PT sweep in progress; fetch must stall
- upd_valid  in  1  AGEX resolved a branch/jump this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  32  actual next PC
- upd_pt_idx  in  8  index carried from lookup
- upd_btb_idx  in  4  index carried from lookup
- stat_lookups  out  32  count of accepted lookups
- stat_btb_hits  out  32  count of accepted lookups that hit the BTB

Behaviour:
- Lookup is combinational from fetch_pc, with no latency.
  - pred_pt_idx = fetch_pc[9:2] ^ BHR.
  - pred_btb_idx = fetch_pc[5:2].
  - pred_btb_hit = valid[idx] && tag[idx] == fetch_pc[31:6].
  - pred_taken = pred_btb_hit && PT[pred_pt_idx][1].
  - pred_next_pc = pred_taken ? target[idx] : fetch_pc + 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0).
- State machine has two states, INIT and RUN.
  - Reset forces INIT with sweep pointer = 0.
  - In INIT, each cycle writes PT[ptr] = 2'b01 (weakly not-taken) and increments ptr.
  - When ptr == PTENTRIES-1 is written, go to RUN. INIT lasts exactly 256 cycles.
  - init_busy = (state == INIT).
  - While in INIT: pred_taken = 0, pred_btb_hit = 0, pred_next_pc = fetch_pc + 4, upd_valid is ignored, and stats do not count.
- Reset values:
  - BHR = 0.
  - All BTB valid bits = 0; tags and targets are don't-care.
  - stat_* = 0; init_busy = 1.
  - Reset asserted mid-sweep or in RUN restarts INIT at ptr 0.
- Update happens on posedge when upd_valid is high in RUN:
  - BHR <= {BHR[6:0], upd_taken}.
  - PT[upd_pt_idx]: increments if upd_taken and < 3; decrements if !upd_taken and > 0; otherwise unchanged (saturation).
  - BTB[upd_btb_idx] is written only if upd_taken: valid = 1, tag = upd_pc[31:6], target = upd_target.
  - A not-taken branch leaves the BTB unchanged.
- A lookup and an update in the same cycle, including to the same entry: the lookup sees pre-update values. There is no bypass.
- Stats:
  - stat_lookups increments on fetch_valid in RUN.
  - stat_btb_hits increments when pred_btb_hit is also high.
  - Both wrap at 2^32.
- Mispredict redirect is owned by FE. This block only predicts.

Decomposition:
- Shared package/defines hold BHRBITS, PTINDEXBITS, BTBINDEXBITS, TAGBITS, the counter encodings (SNT=0, WNT=1, WT=2, ST=3), and the FE<->AGEX metadata width macros.
- One natural sub-module, sat_counter2: a pure next-state function for a 2-bit counter (inputs taken and current value; output next value), instantiated in the PT update path.

Test Plan:
- Reset, then hold fetch_valid with fetch_pc = 0x100 -> init_busy stays high for exactly 256 cycles; pred_next_pc = 0x104; stat_lookups = 0 at the end of INIT.
- After INIT, update pc = 0x200, taken, target 0x400, pt_idx = 0x80 (0x200[9:2] ^ 0 = 0x80), btb_idx = 0 -> BHR = 0x01; PT[0x80] = 2; a lookup of 0x200 needs pt_idx = 0x81 (0x80 ^ 0x01). PT[0x81] is 1, so the result is btb_hit = 1, pred_taken = 0, next = 0x204.
- Two taken updates to PT index 5 -> counter reaches 3; a further taken update keeps it at 3; four not-taken updates saturate it at 0.
- Not-taken update at pc 0x300 with the BTB empty -> lookup of 0x300 gives btb_hit = 0 and pred_target = 0.
- Same-cycle lookup and taken update to the same BTB index -> the lookup reports a miss that cycle and a hit the next cycle.
- Assert reset mid-INIT at ptr 100 -> the sweep restarts from 0 and init_busy stays high a further 256 cycles; also check fetch_pc = 0xFFFFFFFC on a miss gives pred_next_pc = 0.

Source files
------------

// File: rtl/fe_branch_predictor_pkg.sv
// Shared sizing, counter encodings and FSM states for the fetch-stage
// gshare + BTB branch predictor.
package fe_branch_predictor_pkg;

    localparam int DBITS          = 32;
    localparam int BHRBITS        = 8;
    localparam int PTINDEXBITS    = BHRBITS;
    localparam int PTENTRIES      = 256;
    localparam int BTBENTRIES     = 16;
    localparam int BTBINDEXBITS   = 4;
    localparam int TAGBITS        = 26;

    // Metadata carried FE -> DE -> AGEX alongside each predicted instruction
    localparam int PRED_META_BITS = PTINDEXBITS + BTBINDEXBITS;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [PTINDEXBITS-1:0]  pt_idx;
        logic [BTBINDEXBITS-1:0] btb_idx;
    } pred_meta_t;

    function automatic logic [PTINDEXBITS-1:0] gshare_index(
        input logic [DBITS-1:0]   pc,
        input logic [BHRBITS-1:0] bhr
    );
        return pc[PTINDEXBITS+1:2] ^ bhr;
    endfunction

endpackage

// File: rtl/fe_branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import fe_branch_predictor_pkg::*;
(
    input  logic       taken,
    input  logic [1:0] cur,
    output logic [1:0] nxt
);

    // Step one towards the actual direction, holding at either rail
    always_comb begin
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/fe_branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB. Lookups are
// combinational on fetch_pc; resolved branches update state from AGEX.
module fe_branch_predictor
    import fe_branch_predictor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_valid,
    output logic [31:0] pred_next_pc,
    output logic        pred_btb_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [7:0]  pred_pt_idx,
    output logic [3:0]  pred_btb_idx,
    output logic        init_busy,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic [7:0]  upd_pt_idx,
    input  logic [3:0]  upd_btb_idx,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_btb_hits
);

    bp_state_e               state_q, state_d;
    logic [PTINDEXBITS-1:0]  ptr_q, ptr_d;
    logic [BHRBITS-1:0]      bhr_q, bhr_d;
    logic [BTBENTRIES-1:0]   btb_valid_q, btb_valid_d;
    logic [31:0]             stat_lookups_q, stat_lookups_d;
    logic [31:0]             stat_btb_hits_q, stat_btb_hits_d;

    // Tags, targets and counters are not reset: valid bits gate the BTB
    // and the init sweep rewrites every counter.
    logic [TAGBITS-1:0]      btb_tag_q    [BTBENTRIES];
    logic [DBITS-1:0]        btb_target_q [BTBENTRIES];
    logic [1:0]              pt_q         [PTENTRIES];

    logic                    run_s;
    logic                    hit_s;
    logic                    taken_s;
    logic [PTINDEXBITS-1:0]  pt_idx_s;
    logic [BTBINDEXBITS-1:0] btb_idx_s;
    logic                    pt_we_s;
    logic [PTINDEXBITS-1:0]  pt_widx_s;
    logic [1:0]              pt_wdata_s;
    logic [1:0]              pt_upd_next_s;
    logic                    btb_we_s;
    logic                    upd_pc_unused_s;

    assign upd_pc_unused_s = ^upd_pc[5:0];

    sat_counter2 u_sat_counter2 (
        .taken (upd_taken),
        .cur   (pt_q[upd_pt_idx]),
        .nxt   (pt_upd_next_s)
    );

    // Lookup path: reads pre-update state only, no bypass from the update port
    always_comb begin
        run_s     = (state_q == ST_RUN);
        btb_idx_s = fetch_pc[5:2];
        pt_idx_s  = gshare_index(fetch_pc, bhr_q);
        hit_s     = run_s && btb_valid_q[btb_idx_s] &&
                    (btb_tag_q[btb_idx_s] == fetch_pc[31:6]);
        taken_s   = hit_s && pt_q[pt_idx_s][1];
        if (hit_s) begin
            pred_target = btb_target_q[btb_idx_s];
        end else begin
            pred_target = 32'd0;
        end
        if (taken_s) begin
            pred_next_pc = btb_target_q[btb_idx_s];
        end else begin
            pred_next_pc = fetch_pc + 32'd4;
        end
    end

    assign pred_btb_hit  = hit_s;
    assign pred_taken    = taken_s;
    assign pred_pt_idx   = pt_idx_s;
    assign pred_btb_idx  = btb_idx_s;
    assign init_busy     = (state_q == ST_INIT);
    assign stat_lookups  = stat_lookups_q;
    assign stat_btb_hits = stat_btb_hits_q;

    // Init sweep FSM; also selects the pattern-table write port source
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pt_we_s    = 1'b0;
        pt_widx_s  = upd_pt_idx;
        pt_wdata_s = pt_upd_next_s;
        case (state_q)
            ST_INIT: begin
                pt_we_s    = 1'b1;
                pt_widx_s  = ptr_q;
                pt_wdata_s = CTR_WNT;
                ptr_d      = ptr_q + 8'd1;
                if (ptr_q == 8'(PTENTRIES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                pt_we_s = upd_valid;
                ptr_d   = ptr_q;
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = 8'd0;
            end
        endcase
    end

    // History, BTB valid bits and statistics next-state
    always_comb begin
        bhr_d           = bhr_q;
        btb_valid_d     = btb_valid_q;
        btb_we_s        = 1'b0;
        stat_lookups_d  = stat_lookups_q;
        stat_btb_hits_d = stat_btb_hits_q;
        if (run_s && upd_valid) begin
            bhr_d = {bhr_q[BHRBITS-2:0], upd_taken};
            if (upd_taken) begin
                btb_we_s                 = 1'b1;
                btb_valid_d[upd_btb_idx] = 1'b1;
            end else begin
                btb_we_s = 1'b0;
            end
        end else begin
            bhr_d = bhr_q;
        end
        if (run_s && fetch_valid) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
            if (hit_s) begin
                stat_btb_hits_d = stat_btb_hits_q + 32'd1;
            end else begin
                stat_btb_hits_d = stat_btb_hits_q;
            end
        end else begin
            stat_lookups_d = stat_lookups_q;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_INIT;
            ptr_q           <= 8'd0;
            bhr_q           <= 8'd0;
            btb_valid_q     <= 16'd0;
            stat_lookups_q  <= 32'd0;
            stat_btb_hits_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            bhr_q           <= bhr_d;
            btb_valid_q     <= btb_valid_d;
            stat_lookups_q  <= stat_lookups_d;
            stat_btb_hits_q <= stat_btb_hits_d;
        end
    end

    // Storage arrays written from the single PT port and the BTB fill port
    always_ff @(posedge clk) begin
        if (pt_we_s) begin
            pt_q[pt_widx_s] <= pt_wdata_s;
        end
        if (btb_we_s) begin
            btb_tag_q[upd_btb_idx]    <= upd_pc[31:6];
            btb_target_q[upd_btb_idx] <= upd_target;
        end
    end

endmodule
